// File: rtl/uart_tx_queue.sv
// Circular byte FIFO feeding a UART transmitter through its tx_start/din/tx_done_tick handshake.
// Optional dropped-write counter on port ovf_cnt when UART_TXQ_OVF_CNT_EN is defined.
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_done_tick,
    output logic                  busy
`ifdef UART_TXQ_OVF_CNT_EN
    ,
    output logic [7:0]            ovf_cnt
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t              state;
    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign push  = wr_en && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // Only IDLE pops, so exactly one byte can be in flight at a time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_start <= 1'b0;
                    busy     <= 1'b0;
                    if (!empty) begin
                        tx_data  <= mem[rd_ptr[DEPTH_LOG2-1:0]];
                        rd_ptr   <= rd_ptr + PTR_ONE;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    tx_start <= 1'b0;
                    busy     <= 1'b1;
                    state    <= WAIT;
                end
                WAIT: begin
                    tx_start <= 1'b0;
                    if (tx_done_tick) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXQ_OVF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= 8'h00;
        end else if (wr_en && full && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`endif

endmodule
